// File: rtl/disp_pkg.sv
// Shared types and segment constants for the display scan controller.
package disp_pkg;

    // Scan phase within a digit slot.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage : disp_pkg

// File: rtl/bcd2disp.sv
// BCD to active-low 7-segment decoder; codes 10-15 render as '0'.
module bcd2disp
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    // Segment lookup, {g,f,e,d,c,b,a}, low = lit.
    always_comb begin
        seg_c = SEG_ZERO;
        case (bcd)
            4'd0:    seg_c = 7'b1000000;
            4'd1:    seg_c = 7'b1111001;
            4'd2:    seg_c = 7'b0100100;
            4'd3:    seg_c = 7'b0110000;
            4'd4:    seg_c = 7'b0011001;
            4'd5:    seg_c = 7'b0010010;
            4'd6:    seg_c = 7'b0000010;
            4'd7:    seg_c = 7'b1111000;
            4'd8:    seg_c = 7'b0000000;
            4'd9:    seg_c = 7'b0010000;
            default: seg_c = SEG_ZERO;
        endcase
    end

endmodule : bcd2disp

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a guard
// period per slot, double-buffered frame loading and leading-zero blanking.
module disp_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned GUARD_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [6:0]              disp_out,
    output logic                    frame_done
);

    import disp_pkg::*;

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] PCNT_GUARD = PCNT_W'(GUARD_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

    scan_state_t            state;
    scan_state_t            state_next;
    logic [PCNT_W-1:0]      pcnt;
    logic [PCNT_W-1:0]      pcnt_next;
    logic [SLOT_W-1:0]      slot;
    logic [SLOT_W-1:0]      slot_next;

    logic [BCD_W-1:0]       active;
    logic [BCD_W-1:0]       pending;
    logic                   pend_full;

    logic                   frame_end_c;
    logic                   accept_c;
    logic [3:0]             cur_digit_c;
    logic [6:0]             dec_seg_c;
    logic [NUM_DIGITS-1:0]  blank_c;
    logic                   zero_run_c;
    logic [NUM_DIGITS-1:0]  dig_next_c;
    logic [6:0]             seg_next_c;

    // Pending buffer is free whenever it holds nothing.
    assign load_ready = !pend_full;
    assign accept_c   = load_valid && !pend_full;

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the scan phase, slot counter and frame boundary.
    always_comb begin
        state_next  = state;
        pcnt_next   = pcnt;
        slot_next   = slot;
        frame_end_c = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            pcnt_next  = '0;
            slot_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt_next  = '0;
                    slot_next  = '0;
                    state_next = (GUARD_CYC == 0) ? DRIVE : GUARD;
                end
                GUARD, DRIVE: begin
                    if (pcnt == PCNT_LAST) begin
                        pcnt_next = '0;
                        if (slot == SLOT_LAST) begin
                            slot_next   = '0;
                            frame_end_c = 1'b1;
                        end else begin
                            slot_next = slot + 1'b1;
                        end
                    end else begin
                        pcnt_next = pcnt + 1'b1;
                    end
                    state_next = (pcnt_next < PCNT_GUARD) ? GUARD : DRIVE;
                end
                default: begin
                    state_next = IDLE;
                    pcnt_next  = '0;
                    slot_next  = '0;
                end
            endcase
        end
    end

    // Slot cycle counter and current digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            slot <= '0;
        end else begin
            pcnt <= pcnt_next;
            slot <= slot_next;
        end
    end

    // Double buffer: accept into pending, promote to active at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            pend_full <= 1'b0;
            active    <= '0;
        end else if (frame_end_c && pend_full) begin
            active    <= pending;
            pend_full <= 1'b0;
        end else if (accept_c) begin
            pending   <= bcd_in;
            pend_full <= 1'b1;
        end
    end

    // Select the active digit for the current slot.
    always_comb begin
        cur_digit_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_digit_c = active[4*i +: 4];
            end
        end
    end

    // Leading-zero mask: a digit blanks when it and all digits above are zero.
    always_comb begin
        blank_c    = '0;
        zero_run_c = lz_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_c = zero_run_c && (active[4*i +: 4] == 4'd0);
            blank_c[i] = zero_run_c;
        end
    end

    bcd2disp u_bcd2disp (
        .bcd   (cur_digit_c),
        .seg_c (dec_seg_c)
    );

    // Pin values for the next cycle: one digit and its segments only in DRIVE.
    always_comb begin
        dig_next_c = '1;
        seg_next_c = SEG_BLANK;
        if (state == DRIVE) begin
            dig_next_c[slot] = 1'b0;
            seg_next_c       = blank_c[slot] ? SEG_BLANK : dec_seg_c;
        end
    end

    // Registered display pins and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel_n  <= '1;
            disp_out   <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            dig_sel_n  <= dig_next_c;
            disp_out   <= seg_next_c;
            frame_done <= frame_end_c;
        end
    end

endmodule : disp_scan_ctrl

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one `bcd2disp` decoder across `NUM_DIGITS` digits. A prescaled refresh counter steps through the digit slots, and each slot begins with an anti-ghosting guard period. New display values are accepted through a valid/ready handshake and double-buffered, so a frame is never torn. The block sits between the datapath's BCD result registers and the board's segment and digit-enable pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (≥2).
- `PRESCALE`, 50000: clock cycles per digit slot (≥2).
- `GUARD_CYC`, 2: cycles at the start of each slot during which all digits are off (0 ≤ `GUARD_CYC` < `PRESCALE`).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning enabled.
- `bcd_in` in 4*`NUM_DIGITS`: new display value; digit i is at bits [4i+3:4i], and digit 0 is the least significant.
- `load_valid` in 1: `bcd_in` is valid.
- `load_ready` out 1: the pending buffer is empty.
- `lz_blank` in 1: enables leading-zero blanking.
- `dig_sel_n` out `NUM_DIGITS`: active-low one-hot digit enable.
- `disp_out` out 7: active-low segments, same encoding as `bcd2disp`.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
Registers:
- `active`: the frame currently displayed.
- `pending` plus `pend_full`: the buffered next value.
- `pcnt`: slot cycle counter, 0..`PRESCALE`-1.
- `slot`: current digit, 0..`NUM_DIGITS`-1.
- `state`: one of IDLE, GUARD, DRIVE.

Handshake:
- `load_ready` = !`pend_full`.
- Accept occurs when `load_valid && load_ready`: `pending` ← `bcd_in` and `pend_full` ← 1.

Frame boundary (last cycle of the slot `NUM_DIGITS`-1, i.e. `pcnt`==`PRESCALE`-1):
- If `pend_full`, then `active` ← `pending` and `pend_full` ← 0.
- `frame_done` pulses.
- An accept cannot coincide with a transfer, because `load_ready` is low whenever a transfer is possible.

States:
- **IDLE**: entered on reset or whenever `enable`=0, from any state, on the next edge. `pcnt`=0 and `slot`=0. `pending` and `active` are retained, and the handshake still operates.
- IDLE→GUARD when `enable`=1.
- **GUARD**: active while `pcnt` < `GUARD_CYC`. All digits are off.
- GUARD→DRIVE when `pcnt` reaches `GUARD_CYC`. If `GUARD_CYC`=0, GUARD is skipped.
- **DRIVE**:
  - `dig_sel_n` drives bit `slot` low.
  - `disp_out` = `bcd2disp`(`active` digit `slot`).
  - At `pcnt`=`PRESCALE`-1: `pcnt` ← 0, `slot` wraps modulo `NUM_DIGITS`, and the next state is GUARD (or DRIVE if `GUARD_CYC`=0).

Leading-zero blanking:
- Applies to digit i (i ≠ 0) when `lz_blank`=1 and `active` digits `NUM_DIGITS`-1 down to i are all 0.
- A blanked digit is still enabled on `dig_sel_n`, but `disp_out` = 7'h7F.
- Digit 0 is never blanked.

Non-BCD codes (10–15) display '0', matching the decoder default.

## Timing
- Reset values:
  - `dig_sel_n` = all ones
  - `disp_out` = 7'h7F
  - `load_ready` = 1
  - `frame_done` = 0
  - `active` = 0, `pending` = 0
  - state = IDLE
- `dig_sel_n`, `disp_out` and `frame_done` are registered: they show the state/`slot` of the previous cycle (1-cycle latency).
- `load_ready` is combinational from `pend_full`.
- Slot length is exactly `PRESCALE` cycles. Frame length is `NUM_DIGITS`*`PRESCALE` cycles.
- A value accepted at cycle t appears starting at the first slot 0 after the next frame boundary.
- `enable` falling mid-slot: outputs are off (all ones / 7'h7F) two edges later. There is no `frame_done` pulse and no transfer.
- Asynchronous reset mid-frame: all outputs take their reset values immediately, and `pending` is discarded.

## Structure
- A shared package `disp_pkg` holds the state enum (IDLE, GUARD, DRIVE) and the constants `SEG_BLANK` = 7'h7F and `SEG_ZERO` = 7'b1000000.
- `bcd2disp` is instantiated once as the sole sub-module. Its input mux and blanking override are local to this block.

## Test plan
All scenarios use `NUM_DIGITS`=4, `PRESCALE`=8, `GUARD_CYC`=2.

1. Reset, then `enable`=1 and load 16'h1234:
   - Slot 0 shows `dig_sel_n`=4'b1110 with `disp_out`=7'b0011001 ('4').
   - Slot 3 shows 4'b0111 with 7'b1111001 ('1').
   - Each digit is off for 2 cycles per slot.
2. Load 16'h0000, then 16'h0950, with `lz_blank`=1:
   - In the 0x0000 frame, only digit 0 shows '0'.
   - In the 0x0950 frame, digit 3 is blanked (7'h7F) and digits 2..0 show '9', '5', '0'.
3. Hold `load_valid` high with changing data:
   - `load_ready` drops after the first accept.
   - It rises one cycle after the `frame_done` transfer.
   - There is never more than one accept per frame, and each frame shows a single consistent value.
4. Deassert `enable` mid-slot 2:
   - Two edges later, outputs are all-off.
   - On re-enable, the scan restarts at slot 0 with a guard period.
   - The pending value is preserved.
5. Load digits of 4'hC: that digit shows '0' (7'b1000000).
6. Assert `rst_n`=0 mid-DRIVE with pending data:
   - Outputs take their reset values immediately.
   - After release, `active`=0 and `load_ready`=1.
